// File: rtl/encode.sv
// ---------------------------------------------------------------------------
// encode -- extended Hamming (8,4) SECDED channel encoder with serialiser.
//
// A 4-bit nibble is sampled once per 8-clock frame.  The nibble is encoded
// into an 8-bit SECDED codeword, which is then sent MSB-first as a serial
// stream.  Frames follow each other back-to-back with no idle cycles.
//
// Ports
//   clk          in   1  system clock, rising edge
//   rst          in   1  synchronous reset, active-high
//   in           in   4  data nibble, sampled only on the load edge (cnt==0)
//   dout         out  1  serial codeword bit, MSB first
//   frame_start  out  1  high while dout carries bit 7 of a frame
//   code         out  8  codeword of the frame currently being sent
//   valid        out  1  low from reset until the first frame is loaded
//
// Codeword layout: {p1, p2, d1, p4, d2, d3, d4, p0}
//   d1..d4 = in[3]..in[0]; p0 gives the whole word even parity.
// ---------------------------------------------------------------------------
module encode (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] in,
  output logic       dout,
  output logic       frame_start,
  output logic [7:0] code,
  output logic       valid
);

  logic [2:0] cnt;       // bit position within the frame; 0 means load
  logic [6:0] shreg;     // remaining bits of the frame, next bit at [6]
  logic [7:0] enc_code;  // combinational encoding of in

  logic d1, d2, d3, d4;
  logic p1, p2, p4, p0;

  always_comb begin
    d1 = in[3];
    d2 = in[2];
    d3 = in[1];
    d4 = in[0];
    p1 = d1 ^ d2 ^ d4;
    p2 = d1 ^ d3 ^ d4;
    p4 = d2 ^ d3 ^ d4;
    p0 = p1 ^ p2 ^ d1 ^ p4 ^ d2 ^ d3 ^ d4;
    enc_code = {p1, p2, d1, p4, d2, d3, d4, p0};
  end

  // Bit 7 leaves directly on the load edge, so the shift register only has
  // to hold bits 6..0 of the codeword.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= 3'd0;
      shreg       <= 7'd0;
      code        <= 8'd0;
      dout        <= 1'b0;
      frame_start <= 1'b0;
      valid       <= 1'b0;
    end else begin
      cnt <= cnt + 3'd1;  // wraps 7 -> 0, giving back-to-back frames
      if (cnt == 3'd0) begin
        code        <= enc_code;
        shreg       <= enc_code[6:0];
        dout        <= enc_code[7];
        frame_start <= 1'b1;
        valid       <= 1'b1;
      end else begin
        shreg       <= {shreg[5:0], 1'b0};
        dout        <= shreg[6];
        frame_start <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_encode.sv
// ---------------------------------------------------------------------------
// tb_encode -- self-checking bench for the encode SECDED serialiser.
// A queue-based bit model predicts every output on every cycle; directed
// frames add literal expectations that pin the model.
// ---------------------------------------------------------------------------
module tb_encode;

  logic       clk;
  logic       rst;
  logic [3:0] in;
  logic       dout;
  logic       frame_start;
  logic [7:0] code;
  logic       valid;

  int tests;
  int fails;

  encode dut (
    .clk         (clk),
    .rst         (rst),
    .in          (in),
    .dout        (dout),
    .frame_start (frame_start),
    .code        (code),
    .valid       (valid)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] enc(input logic [3:0] v);
    logic a, b, c, d, q1, q2, q4;
    a = v[3]; b = v[2]; c = v[1]; d = v[0];
    q1 = a ^ b ^ d;
    q2 = a ^ c ^ d;
    q4 = b ^ c ^ d;
    enc = {q1, q2, a, q4, b, c, d, 1'b0};
    enc[0] = ^enc[7:1];
  endfunction

  // ---------------- model: queue of bits still to be sent ----------------
  logic [0:0] exp_q[$];
  logic       m_dout, m_fs, m_valid, m_live;
  logic [7:0] m_code;

  initial m_live = 1'b0;

  always @(posedge clk) begin
    logic [7:0] c;
    if (rst) begin
      exp_q.delete();
      m_dout = 1'b0; m_fs = 1'b0; m_code = 8'd0; m_valid = 1'b0;
      m_live = 1'b1;
    end else if (m_live) begin
      if (exp_q.size() == 0) begin
        c = enc(in);
        m_code = c;
        for (int i = 7; i >= 0; i--) exp_q.push_back(c[i]);
        m_fs = 1'b1;
        m_valid = 1'b1;
      end else begin
        m_fs = 1'b0;
      end
      m_dout = exp_q.pop_front();
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (m_live) begin
      check("cyc_dout", 32'(dout), 32'(m_dout));
      check("cyc_frame_start", 32'(frame_start), 32'(m_fs));
      check("cyc_code", 32'(code), 32'(m_code));
      check("cyc_valid", 32'(valid), 32'(m_valid));
    end
  end

  // ---------------- driver ----------------
  // Called 2 time units after a rising edge, with the next edge a load edge.
  // Returns the code seen on the first cycle, the 8 serial bits and the
  // frame_start pattern. Optionally changes in after cycle chg_at.
  task automatic run_frame(input logic [3:0] v, input int chg_at, input logic [3:0] chg_v,
                           output logic [7:0] seen_code, output logic [7:0] bits,
                           output logic [7:0] fs_bits);
    in = v;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (i == 0) seen_code = code;
      bits[7-i] = dout;
      fs_bits[7-i] = frame_start;
      if (i == chg_at) in = chg_v;
    end
    #1;
  endtask

  logic [7:0] sc, sb, sf;
  logic [7:0] sweep[16];

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    in = 4'h0;

    // reset for 2 cycles
    @(posedge clk); #1;
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_code", 32'(code), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_fs", 32'(frame_start), 32'd0);
    @(posedge clk); #2;
    rst = 1'b0;

    // in=0: all-zero codeword
    run_frame(4'h0, -1, 4'h0, sc, sb, sf);
    check("f0_code", 32'(sc), 32'h00);
    check("f0_bits", 32'(sb), 32'h00);
    check("f0_fs", 32'(sf), 32'h80);

    // in=1 -> D2, bits 1,1,0,1,0,0,1,0
    run_frame(4'h1, -1, 4'h0, sc, sb, sf);
    check("f1_code", 32'(sc), 32'hD2);
    check("f1_bits", 32'(sb), 32'b11010010);
    check("f1_fs", 32'(sf), 32'h80);

    run_frame(4'h8, -1, 4'h0, sc, sb, sf);
    check("f8_code", 32'(sc), 32'hE1);
    check("f8_bits", 32'(sb), 32'hE1);
    run_frame(4'hF, -1, 4'h0, sc, sb, sf);
    check("fF_code", 32'(sc), 32'hFF);
    check("fF_bits", 32'(sb), 32'hFF);
    run_frame(4'h7, -1, 4'h0, sc, sb, sf);
    check("f7_code", 32'(sc), 32'h1E);
    check("f7_bits", 32'(sb), 32'h1E);

    // sweep 0..F, frame aligned
    for (int v = 0; v < 16; v++) begin
      run_frame(4'(v), -1, 4'h0, sc, sb, sf);
      sweep[v] = sc;
      check("sweep_code", 32'(sc), 32'(enc(4'(v))));
      check("sweep_bits", 32'(sb), 32'(enc(4'(v))));
      check("sweep_parity", 32'(^sc), 32'd0);
    end
    for (int a = 0; a < 16; a++)
      for (int b = a + 1; b < 16; b++)
        check("sweep_distance_ge4", 32'($countones(sweep[a] ^ sweep[b]) >= 4), 32'd1);

    // mid-frame change of in (after cycle 3): frame in flight unaffected
    run_frame(4'h1, 2, 4'hA, sc, sb, sf);
    check("mid_code", 32'(sc), 32'hD2);
    check("mid_bits", 32'(sb), 32'hD2);
    check("mid_fs", 32'(sf), 32'h80);
    run_frame(4'hA, -1, 4'h0, sc, sb, sf);
    check("mid_next_code", 32'(sc), 32'(enc(4'hA)));
    check("mid_next_bits", 32'(sb), 32'(enc(4'hA)));

    // reset at cycle 5 of a frame
    in = 4'h8;
    for (int i = 0; i < 5; i++) @(posedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_dout", 32'(dout), 32'd0);
    check("midrst_code", 32'(code), 32'd0);
    check("midrst_valid", 32'(valid), 32'd0);
    check("midrst_fs", 32'(frame_start), 32'd0);
    #1;
    rst = 1'b0;
    run_frame(4'h7, -1, 4'h0, sc, sb, sf);
    check("postrst_code", 32'(sc), 32'h1E);
    check("postrst_bits", 32'(sb), 32'h1E);
    check("postrst_fs", 32'(sf), 32'h80);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
